rgb_fade_sequencer: RTL and testbench

- Command-driven controller that sequences the three 8-bit RGB channel values feeding the per-channel delta-sigma LED modulators.
- Accepts colour commands (target RGB, step rate, hold time) over a valid/ready port into a small FIFO.
- Ramps the current colour linearly toward each target, holds it, then moves on to the next command.
- Sits between the SPI command decoder and the RGB delta-sigma datapath.

---
 rtl/rgb_pkg.sv | 82 ++++++++
 rtl/rgb_cmd_fifo.sv | 55 +++++
 rtl/rgb_fade_sequencer.sv | 157 +++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types, FSM encoding, ramp helpers and gamma table for
// rgb_fade_sequencer and its command FIFO.
package rgb_pkg;

  // Field widths carried through the command FIFO; the top-level RATE_W and
  // HOLD_W must not exceed these.
  localparam int CMD_RATE_W = 16;
  localparam int CMD_HOLD_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t                  rgb;
    logic [CMD_RATE_W-1:0] rate;
    logic [CMD_HOLD_W-1:0] hold;
  } fade_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FADE,
    ST_HOLD
  } fade_state_e;

  typedef logic [255:0][7:0] gamma_lut_t;

  // One unit step of a channel toward its target; never overshoots or wraps.
  function automatic logic [7:0] step_chan(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    res = cur;
    if (cur < tgt)      res = cur + 8'd1;
    else if (cur > tgt) res = cur - 8'd1;
    return res;
  endfunction

  function automatic rgb_t step_rgb(input rgb_t cur, input rgb_t tgt);
    rgb_t res;
    res.r = step_chan(cur.r, tgt.r);
    res.g = step_chan(cur.g, tgt.g);
    res.b = step_chan(cur.b, tgt.b);
    return res;
  endfunction

  // Exact integer gamma-2.2 table, rounded to nearest.
  // 2.2 = 11/5, so y = 255*(i/255)^2.2 satisfies y^5 = i^11 / 255^6.
  // round(y) is the largest t with (t - 0.5)^5 <= y^5, i.e.
  // (2t-1)^5 * 255^6 <= 32 * i^11, found by an 8-step binary search.
  function automatic gamma_lut_t gamma_build();
    gamma_lut_t   lut;
    logic [127:0] s6;
    logic [127:0] rhs;
    logic [127:0] lhs;
    logic [127:0] odd;
    logic [7:0]   y;
    logic [7:0]   t;
    s6 = 128'd1;
    for (int k = 0; k < 6; k++) s6 = s6 * 128'd255;
    for (int i = 0; i < 256; i++) begin
      rhs = 128'd32;
      for (int k = 0; k < 11; k++) rhs = rhs * 128'(i);
      y = '0;
      for (int bit_i = 7; bit_i >= 0; bit_i--) begin
        t   = y | (8'd1 << bit_i);
        odd = 128'({t, 1'b0}) - 128'd1;
        lhs = s6;
        for (int k = 0; k < 5; k++) lhs = lhs * odd;
        if (lhs <= rhs) y = t;
      end
      lut[i] = y;
    end
    return lut;
  endfunction

`ifdef RGB_FADE_GAMMA_EN
  localparam gamma_lut_t GAMMA_LUT = gamma_build();
`endif

endpackage

// File: rtl/rgb_cmd_fifo.sv
// rgb_cmd_fifo: synchronous FIFO of fade commands with full/empty flags,
// synchronous active-high reset and a flush input that empties it in one cycle.
module rgb_cmd_fifo
  import rgb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush_i,
  input  logic      push_i,
  input  fade_cmd_t wr_data_i,
  input  logic      pop_i,
  output fade_cmd_t rd_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  fade_cmd_t        mem_q [DEPTH];
  logic      [AW:0] wr_ptr_q;
  logic      [AW:0] rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so stale data is never observed.
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: queues colour commands and ramps the three 8-bit LED
// channel values linearly toward each target, holds, then takes the next one.
// Optional macro RGB_FADE_GAMMA_EN adds a registered gamma-2.2 output stage.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RATE_W     = 16,
  parameter int HOLD_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [23:0]       cmd_rgb,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic [7:0]        led_r_out,
  output logic [7:0]        led_g_out,
  output logic [7:0]        led_b_out,
  output logic              busy,
  output logic              done_pulse
);

  fade_state_e       state_q, state_d;
  rgb_t              cur_q, cur_d;
  fade_cmd_t         cmd_q, cmd_d;
  logic [RATE_W-1:0] tick_q, tick_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  fade_cmd_t         fifo_wr;
  fade_cmd_t         fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              tick;

  assign cmd_ready = !fifo_full && !abort;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign tick      = (tick_q == cmd_q.rate[RATE_W-1:0]);

  // Widen the command fields into the FIFO entry format.
  always_comb begin
    fifo_wr      = '0;
    fifo_wr.rgb  = rgb_t'(cmd_rgb);
    fifo_wr.rate = CMD_RATE_W'(cmd_rate);
    fifo_wr.hold = CMD_HOLD_W'(cmd_hold);
  end

  rgb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (abort),
    .push_i    (cmd_valid && cmd_ready),
    .wr_data_i (fifo_wr),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Next-state, ramp and counter logic; abort overrides, pause freezes all.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cur_d      = cur_q;
    cmd_d      = cmd_q;
    tick_d     = tick_q;
    hold_d     = hold_q;
    fifo_pop   = 1'b0;
    done_pulse = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cmd_d    = fifo_rd;
            state_d  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          tick_d  = '0;
          state_d = ST_FADE;
        end
        ST_FADE: begin
          if (cur_q == cmd_q.rgb) begin
            // Restart the step period so each hold tick is a whole period.
            state_d = ST_HOLD;
            hold_d  = cmd_q.hold[HOLD_W-1:0];
            tick_d  = '0;
          end else begin
            tick_d = tick ? '0 : tick_q + 1'b1;
            if (tick) cur_d = step_rgb(cur_q, cmd_q.rgb);
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_d    = ST_IDLE;
            done_pulse = 1'b1;
          end else begin
            tick_d = tick ? '0 : tick_q + 1'b1;
            if (tick) hold_d = hold_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, ramp and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cmd_q   <= '0;
      tick_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cmd_q   <= cmd_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  rgb_t led_q;

  // Registered gamma lookup of the linear ramp values.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q.r <= GAMMA_LUT[cur_q.r];
      led_q.g <= GAMMA_LUT[cur_q.g];
      led_q.b <= GAMMA_LUT[cur_q.b];
    end
  end

  assign led_r_out = led_q.r;
  assign led_g_out = led_q.g;
  assign led_b_out = led_q.b;
`else
  assign led_r_out = cur_q.r;
  assign led_g_out = cur_q.g;
  assign led_b_out = cur_q.b;
`endif

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed self-checking bench for rgb_fade_sequencer.
module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_rgb;
  logic [15:0] cmd_rate;
  logic [15:0] cmd_hold;
  logic [7:0]  led_r_out;
  logic [7:0]  led_g_out;
  logic [7:0]  led_b_out;
  logic        busy;
  logic        done_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected values after each of the 7 edges following the push of
  // 0x030201 (rate 0, hold 0): pop, load, three steps, arrive, idle.
  logic [7:0] exp_r [7] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
  logic [7:0] exp_g [7] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
  logic [7:0] exp_b [7] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
  logic       exp_d [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [23:0] q_rgb [5] = '{24'hFFFFFF, 24'h000000, 24'h102030, 24'h0A0B0C, 24'h050607};

  rgb_fade_sequencer #(
    .FIFO_DEPTH (4),
    .RATE_W     (16),
    .HOLD_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .abort      (abort),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rgb    (cmd_rgb),
    .cmd_rate   (cmd_rate),
    .cmd_hold   (cmd_hold),
    .led_r_out  (led_r_out),
    .led_g_out  (led_g_out),
    .led_b_out  (led_b_out),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // Present one command and hold it until accepted (bounded wait).
  task automatic push_cmd(input logic [23:0] rgb, input logic [15:0] rate, input logic [15:0] hold);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_rgb   = rgb;
    cmd_rate  = rate;
    cmd_hold  = hold;
    while (!cmd_ready && waited < 500) begin
      cyc(1);
      waited++;
    end
    if (!cmd_ready) check("push_accept_timeout", 32'(cmd_ready), 32'd1);
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int first_r1;
    int first_r2;
    int done_at;
    int done_seen;
    int wrap_err;
    logic [7:0] prev_r;

    rst       = 1'b1;
    enable    = 1'b1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rgb   = '0;
    cmd_rate  = '0;
    cmd_hold  = '0;

    // Reset and idle.
    do_reset();
    check("rst_led_rgb", {led_r_out, led_g_out, led_b_out}, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_done", done_pulse, 1'b0);
    cyc(3);
    check("idle_busy", busy, 1'b0);

    // Single fast command: r 0->3 one step per cycle, g/b stop earlier.
    push_cmd(24'h030201, 16'd0, 16'd0);
    check("single_busy_after_push", busy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check($sformatf("single_r_c%0d", i + 1), led_r_out, exp_r[i]);
      check($sformatf("single_g_c%0d", i + 1), led_g_out, exp_g[i]);
      check($sformatf("single_b_c%0d", i + 1), led_b_out, exp_b[i]);
      check($sformatf("single_done_c%0d", i + 1), done_pulse, exp_d[i]);
    end
    check("single_idle_busy", busy, 1'b0);

    // rate=3, hold=2, r 0->2: a step every 4 cycles, hold adds 8 cycles.
    do_reset();
    push_cmd(24'h020000, 16'd3, 16'd2);
    first_r1  = 0;
    first_r2  = 0;
    done_at   = 0;
    done_seen = 0;
    for (int c = 1; c <= 24; c++) begin
      cyc(1);
      if (led_r_out == 8'd1 && first_r1 == 0) first_r1 = c;
      if (led_r_out == 8'd2 && first_r2 == 0) first_r2 = c;
      if (done_pulse) begin
        done_seen++;
        if (done_at == 0) done_at = c;
      end
    end
    check("rate3_first_step", first_r1, 6);
    check("rate3_second_step", first_r2, 10);
    check("hold2_done_cycle", done_at, 19);
    check("hold2_done_count", done_seen, 1);
    check("hold2_idle_busy", busy, 1'b0);

    // Five back-to-back commands into a 4-deep queue.
    push_cmd(q_rgb[0], 16'd0, 16'd0);
    push_cmd(q_rgb[1], 16'd0, 16'd0);
    push_cmd(q_rgb[2], 16'd0, 16'd0);
    push_cmd(q_rgb[3], 16'd0, 16'd0);
    push_cmd(q_rgb[4], 16'd1, 16'd1);
    check("queue_full_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_rgb   = 24'hDEAD00;
    cyc(2);
    check("queue_still_full", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    wrap_err  = 0;
    for (int k = 0; k < 5; k++) begin
      cnt    = 0;
      prev_r = led_r_out;
      while (!done_pulse && cnt < 2000) begin
        cyc(1);
        cnt++;
        if (k == 1 && led_r_out > prev_r) wrap_err++;
        prev_r = led_r_out;
      end
      check($sformatf("queue_done_%0d", k), done_pulse, 1'b1);
      check($sformatf("queue_rgb_%0d", k), {led_r_out, led_g_out, led_b_out}, q_rgb[k]);
      cyc(1);
    end
    check("down_ramp_no_wrap", wrap_err, 0);
    check("queue_drained_busy", busy, 1'b0);

    // Pause: baseline fade, then the same distance with 10 paused cycles.
    push_cmd(24'h151617, 16'd1, 16'd0);
    cnt = 0;
    while (!done_pulse && cnt < 300) begin
      cyc(1);
      cnt++;
    end
    check("fade_base_cycles", cnt, 35);
    cyc(1);
    push_cmd(24'h050607, 16'd1, 16'd0);
    cyc(10);
    cnt = 10;
    check("pre_pause_r", led_r_out, 8'h11);
    enable = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      cnt++;
      if (done_pulse) done_seen++;
    end
    check("pause_rgb_frozen", {led_r_out, led_g_out, led_b_out}, 24'h111213);
    check("pause_no_done", done_seen, 0);
    enable = 1'b1;
    while (!done_pulse && cnt < 300) begin
      cyc(1);
      cnt++;
    end
    check("fade_paused_cycles", cnt, 45);
    cyc(1);

    // Abort with a simultaneous push attempt, two commands queued.
    push_cmd(24'h808080, 16'd0, 16'd0);
    push_cmd(24'h112233, 16'd0, 16'd0);
    push_cmd(24'h445566, 16'd0, 16'd0);
    cyc(5);
    check("abort_pre_rgb", {led_r_out, led_g_out, led_b_out}, 24'h0A0B0C);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_rgb   = 24'h778899;
    #1;
    check("abort_ready_low", cmd_ready, 1'b0);
    check("abort_cycle_done", done_pulse, 1'b0);
    cyc(1);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abort_idle_empty", busy, 1'b0);
    check("abort_rgb_held", {led_r_out, led_g_out, led_b_out}, 24'h0A0B0C);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (done_pulse) done_seen++;
    end
    check("abort_no_done_after", done_seen, 0);
    check("abort_rgb_kept", {led_r_out, led_g_out, led_b_out}, 24'h0A0B0C);
    check("abort_stays_idle", busy, 1'b0);

    // Reset in the middle of a fade.
    push_cmd(24'hFFFFFF, 16'd0, 16'd0);
    push_cmd(24'h010101, 16'd0, 16'd0);
    cyc(8);
    check("rst_mid_pre_r", led_r_out, 8'h11);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_rgb", {led_r_out, led_g_out, led_b_out}, 32'h0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", cmd_ready, 1'b1);
    cyc(5);
    check("rst_mid_rgb_stays", {led_r_out, led_g_out, led_b_out}, 32'h0);
    check("rst_mid_busy_stays", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
